// File: rtl/core_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding, counter width
// and the byte-to-word index split used by the address check.
package core_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // Word index starts above the two byte-offset bits of a 32-bit word address.
    localparam int WORD_IDX_LSB = 2;

    // Wide enough for LATENCY-1 with LATENCY up to 15.
    localparam int CNT_W = 4;

    function automatic int word_idx_width(input int dwidth);
        return dwidth - WORD_IDX_LSB;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bus between the MEM-stage initiator and the data-memory responder.
// Both channels use a valid/ready handshake.
interface dmem_responder_if #(
    parameter int DWIDTH = 32
) ();

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [DWIDTH-1:0] req_addr;
    logic [DWIDTH-1:0] req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [DWIDTH-1:0] resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

endinterface

// File: rtl/dmem_word_array.sv
// SIZE x DWIDTH word storage: combinational read by index, synchronous write,
// synchronous clear of every word while rst is high.
module dmem_word_array #(
    parameter int DWIDTH = 32,
    parameter int SIZE   = 64,
    parameter int AW     = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [AW-1:0]     idx,
    input  logic [DWIDTH-1:0] wdata,
    output logic [DWIDTH-1:0] rdata
);

    logic [DWIDTH-1:0] mem [SIZE];
    logic [SIZE-1:0]   wr_sel;

    genvar gi;
    generate
        for (gi = 0; gi < SIZE; gi++) begin : gen_wr_sel
            assign wr_sel[gi] = we && (idx == AW'(gi));
        end
    endgenerate

    // Register-based so the whole array can be cleared in one reset cycle.
    always_ff @(posedge clk) begin
        for (int i = 0; i < SIZE; i++) begin
            if (rst) begin
                mem[i] <= '0;
            end else if (wr_sel[i]) begin
                mem[i] <= wdata;
            end
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory slave: accepts one word access, waits LATENCY cycles,
// then holds a response until the initiator consumes it.
module dmem_responder
    import core_pkg::*;
#(
    parameter int DWIDTH  = 32,
    parameter int SIZE    = 64,
    parameter int LATENCY = 2
) (
    input logic            clk,
    input logic            rst,
    dmem_responder_if.slave bus
);

    localparam int IW = word_idx_width(DWIDTH);
    localparam int AW = (SIZE > 1) ? $clog2(SIZE) : 1;

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic              we_reg;
    logic [DWIDTH-1:0] addr_reg;
    logic [DWIDTH-1:0] wdata_reg;
    logic [DWIDTH-1:0] rdata_reg;
    logic              err_reg;

    logic              accept;
    logic              commit;
    logic              resp_done;
    logic [IW-1:0]     idx;
    logic              addr_err;
    logic              mem_we;
    logic [DWIDTH-1:0] mem_rdata;

    assign idx      = addr_reg[DWIDTH-1:WORD_IDX_LSB];
    assign addr_err = (addr_reg[WORD_IDX_LSB-1:0] != '0) || (idx >= IW'(SIZE));
    assign mem_we   = commit && we_reg && !addr_err;

    dmem_word_array #(
        .DWIDTH (DWIDTH),
        .SIZE   (SIZE),
        .AW     (AW)
    ) u_word_array (
        .clk   (clk),
        .rst   (rst),
        .we    (mem_we),
        .idx   (idx[AW-1:0]),
        .wdata (wdata_reg),
        .rdata (mem_rdata)
    );

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        accept     = 1'b0;
        commit     = 1'b0;
        resp_done  = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (bus.req_valid) begin
                    accept     = 1'b1;
                    cnt_next   = CNT_W'(LATENCY - 1);
                    state_next = S_BUSY;
                end
            end
            S_BUSY: begin
                if (cnt_reg == '0) begin
                    commit     = 1'b1;
                    state_next = S_RESP;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            S_RESP: begin
                if (bus.resp_ready) begin
                    resp_done  = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
            cnt_reg   <= '0;
            we_reg    <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            rdata_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            // Request fields are captured once; the bus may change freely afterwards.
            if (accept) begin
                we_reg    <= bus.req_we;
                addr_reg  <= bus.req_addr;
                wdata_reg <= bus.req_wdata;
            end
            if (commit) begin
                err_reg   <= addr_err;
                rdata_reg <= (addr_err || we_reg) ? '0 : mem_rdata;
            end
            if (resp_done) begin
                rdata_reg <= '0;
                err_reg   <= 1'b0;
            end
        end
    end

    assign bus.req_ready  = (state_reg == S_IDLE) && !rst;
    assign bus.resp_valid = (state_reg == S_RESP);
    assign bus.resp_rdata = rdata_reg;
    assign bus.resp_err   = err_reg;

endmodule
